mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Two-to-one arbiter between the icache and dcache memory-side ports and the single main-memory port.
//  Each cache sees a private memory port. The arbiter latches one request, drives it downstream and waits for mem_done.
//  It then returns read data with a one-cycle done pulse to the granted cache.
// PARAMETERS
//  ADDR_WIDTH  32  request address width
//  DATA_WIDTH  32  read/write data width
//  MASK_WIDTH   4  byte write-mask width (DATA_WIDTH/8)
// PORTS
//  clk             in   1   single clock; all state updates on rising edge
//  rst             in   1   synchronous, active-low reset
//  ic_rw_flag      in   2   icache request: [0] read, [1] write, 00 idle
//  ic_addr         in   ADDR_WIDTH  icache address
//  ic_write_data   in   DATA_WIDTH  icache write data
//  ic_write_mask   in   MASK_WIDTH  icache byte mask
//  ic_read_data    out  DATA_WIDTH  read data to icache, registered
//  ic_busy         out  1   port occupied; icache must not start a new request
//  ic_done         out  1   one-cycle completion pulse to icache
//  dc_*            same set as ic_*, for the dcache
//  mem_rw_flag     out  2   downstream request, held until mem_done
//  mem_addr        out  ADDR_WIDTH  latched address
//  mem_write_data  out  DATA_WIDTH  latched write data
//  mem_write_mask  out  MASK_WIDTH  latched mask
//  mem_read_data   in   DATA_WIDTH  memory read data, valid with mem_done
//  mem_busy        in   1   memory cannot accept a new request
//  mem_done        in   1   one-cycle completion pulse from memory
// BEHAVIOUR
//  Reset (rst==0 at edge): state IDLE; every output 0; priority pointer set to dcache.
//   Reset mid-transaction drops mem_rw_flag at once and issues no done.
//  Requester contract: rw_flag!=00 and addr/data/mask are held stable until done; rw_flag may change the cycle after done.
//  rw_flag 11 is illegal and is treated as a write (bit[1] wins). mem_rw_flag is then 10.
//  FSM:
//   IDLE -> REQ when any rw_flag!=00 and mem_busy==0.
//    On that edge: select the winner, latch its addr/data/mask/flag into the mem_* registers, record grant.
//    While mem_busy==1 the FSM stays in IDLE and grants nothing.
//   REQ  -> RESP on mem_done. mem_rw_flag stays at the latched value through REQ.
//    On the mem_done edge: mem_rw_flag goes to 00; mem_read_data is captured into the granted master's read_data.
//    Write requests also capture it; the value is don't-care to the requester.
//   RESP -> IDLE unconditionally. Granted <x>_done = 1 for exactly this cycle.
//    Non-granted read_data holds its previous value.
//  Busy: ic_busy = dc_busy = 1 in REQ and RESP (registered, set on the grant edge), 0 in IDLE.
//  Latency: request visible in cycle 0 -> mem_rw_flag in cycle 1 -> mem_done in cycle N -> <x>_done in cycle N+1.
//   Minimum 3 cycles per transaction; back-to-back requests from one master are separated by one IDLE cycle.
//  Simultaneous requests: dcache wins (fixed priority). The loser stays pending and is granted in the next IDLE.
//  mem_done outside REQ is ignored.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: one-bit pointer, flipped to the non-granted master after each grant.
//   On a tie the pointer's master wins; a lone requester always wins.
//  Undefined: fixed dcache priority; no pointer flop.
// STRUCTURE
//  Shared package mem_arb_pkg:
//   state encoding IDLE=2'd0, REQ=2'd1, RESP=2'd2
//   RW_IDLE=2'b00, RW_READ=2'b01, RW_WRITE=2'b10
//   master IDs GNT_IC=1'b0, GNT_DC=1'b1
//  Sub-module mem_arb_grant: winner select from two request bits plus the pointer. The pointer is only used under MEM_ARB_ROUND_ROBIN_EN.
//  The arbiter top holds the FSM, latch registers and response registers.
// TESTING
//  1 Reset: hold rst=0 with both rw_flag=01 -> all outputs 0; no grant until rst=1.
//  2 Single read: ic_rw_flag=01, ic_addr=0x0000_1000; memory returns 0xDEAD_BEEF with mem_done 4 cycles later.
//    -> mem_addr=0x1000 and mem_rw_flag=01 from cycle 1; ic_read_data=0xDEAD_BEEF and ic_done pulse 1 cycle after mem_done.
//  3 Tie: both request in the same cycle (dc write 0x2000 data 0x1234_5678 mask 0011; ic read 0x40).
//    -> dcache served first with mem_write_mask=0011; icache served after the intervening IDLE cycle.
//    With MEM_ARB_ROUND_ROBIN_EN, a second tie grants icache first.
//  4 Backpressure: mem_busy=1 for 5 cycles while dc_rw_flag=01 -> mem_rw_flag stays 00 and busy stays 0; grant on the first cycle mem_busy=0.
//  5 Reset mid-REQ: rst=0 two cycles after grant -> mem_rw_flag=00 next edge; no done. After release, a new request completes normally.
//  6 Illegal flag 11 from dcache -> mem_rw_flag=10; stray mem_done in IDLE produces no done pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-to-one memory arbiter.
//               Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   // Default bus geometry
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_MASK_WIDTH = DEF_DATA_WIDTH / 8;

   // Arbiter FSM encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   // Request flag encoding
   localparam logic [1:0] RW_IDLE  = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b01;
   localparam logic [1:0] RW_WRITE = 2'b10;

   // Master identifiers
   localparam logic GNT_IC = 1'b0;
   localparam logic GNT_DC = 1'b1;

   // Collapse the illegal 11 encoding onto a write: bit[1] dominates.
   function automatic logic [1:0] norm_rw(input logic [1:0] flag);
      if (flag[1]) begin
         return RW_WRITE;
      end else if (flag[0]) begin
         return RW_READ;
      end
      return RW_IDLE;
   endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_if
// Description : Bundle of icache, dcache and main-memory request/response
//               signals. The arbiter connects through the slave modport,
//               the requesters/memory environment through the master one.
//               Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (no effect here)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MASK_WIDTH = 4
);

   // icache side
   logic [1:0]            ic_rw_flag;
   logic [ADDR_WIDTH-1:0] ic_addr;
   logic [DATA_WIDTH-1:0] ic_write_data;
   logic [MASK_WIDTH-1:0] ic_write_mask;
   logic [DATA_WIDTH-1:0] ic_read_data;
   logic                  ic_busy;
   logic                  ic_done;

   // dcache side
   logic [1:0]            dc_rw_flag;
   logic [ADDR_WIDTH-1:0] dc_addr;
   logic [DATA_WIDTH-1:0] dc_write_data;
   logic [MASK_WIDTH-1:0] dc_write_mask;
   logic [DATA_WIDTH-1:0] dc_read_data;
   logic                  dc_busy;
   logic                  dc_done;

   // main-memory side
   logic [1:0]            mem_rw_flag;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_write_data;
   logic [MASK_WIDTH-1:0] mem_write_mask;
   logic [DATA_WIDTH-1:0] mem_read_data;
   logic                  mem_busy;
   logic                  mem_done;

   // Arbiter view
   modport slave (
      input  ic_rw_flag, ic_addr, ic_write_data, ic_write_mask,
      output ic_read_data, ic_busy, ic_done,
      input  dc_rw_flag, dc_addr, dc_write_data, dc_write_mask,
      output dc_read_data, dc_busy, dc_done,
      output mem_rw_flag, mem_addr, mem_write_data, mem_write_mask,
      input  mem_read_data, mem_busy, mem_done
   );

   // Requester / memory environment view
   modport master (
      output ic_rw_flag, ic_addr, ic_write_data, ic_write_mask,
      input  ic_read_data, ic_busy, ic_done,
      output dc_rw_flag, dc_addr, dc_write_data, dc_write_mask,
      input  dc_read_data, dc_busy, dc_done,
      input  mem_rw_flag, mem_addr, mem_write_data, mem_write_mask,
      output mem_read_data, mem_busy, mem_done
   );

endinterface : mem_arb_if
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_grant
// Description : Winner select between icache and dcache request bits.
//               Fixed dcache priority by default; with MEM_ARB_ROUND_ROBIN_EN
//               a tie is resolved in favour of the pointer's master.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic ic_req_i,
   input  logic dc_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic ptr_i,
`endif
   output logic valid_o,
   output logic gnt_o
);

   // Pick a winner; a lone requester always wins.
   always_comb begin
      valid_o = ic_req_i | dc_req_i;
      gnt_o   = GNT_IC;
      if (ic_req_i && dc_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         gnt_o = ptr_i;
`else
         gnt_o = GNT_DC;
`endif
      end else if (dc_req_i) begin
         gnt_o = GNT_DC;
      end
   end

endmodule : mem_arb_grant
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-to-one arbiter between the icache and dcache memory ports
//               and one main-memory port. Latches one request, holds it on
//               the memory port until mem_done, then returns read data with a
//               one-cycle done pulse to the granted cache.
//               Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin
//               tie break instead of fixed dcache priority).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MASK_WIDTH = DEF_MASK_WIDTH
) (
   input  logic      clk,
   input  logic      rst,
   mem_arb_if.slave  bus_if
);

   state_t                state_q, state_d;
   logic                  gnt_q, gnt_d;
   logic                  busy_q, busy_d;
   logic [1:0]            mem_rw_q, mem_rw_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [MASK_WIDTH-1:0] mem_wmask_q, mem_wmask_d;
   logic [DATA_WIDTH-1:0] ic_rdata_q, ic_rdata_d;
   logic [DATA_WIDTH-1:0] dc_rdata_q, dc_rdata_d;
   logic                  ic_done_q, ic_done_d;
   logic                  dc_done_q, dc_done_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic                  ptr_q, ptr_d;
`endif

   logic w_ic_req;
   logic w_dc_req;
   logic w_req_valid;
   logic w_gnt;

   assign w_ic_req = (bus_if.ic_rw_flag != RW_IDLE);
   assign w_dc_req = (bus_if.dc_rw_flag != RW_IDLE);

   mem_arb_grant u_grant (
      .ic_req_i (w_ic_req),
      .dc_req_i (w_dc_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .ptr_i    (ptr_q),
`endif
      .valid_o  (w_req_valid),
      .gnt_o    (w_gnt)
   );

   // Next-state and next-register values; every field defaults to hold.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      busy_d      = busy_q;
      mem_rw_d    = mem_rw_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = mem_wmask_q;
      ic_rdata_d  = ic_rdata_q;
      dc_rdata_d  = dc_rdata_q;
      ic_done_d   = 1'b0;
      dc_done_d   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            // Memory backpressure blocks the grant entirely.
            if (w_req_valid && !bus_if.mem_busy) begin
               state_d = REQ;
               gnt_d   = w_gnt;
               busy_d  = 1'b1;
               if (w_gnt == GNT_DC) begin
                  mem_rw_d    = norm_rw(bus_if.dc_rw_flag);
                  mem_addr_d  = bus_if.dc_addr;
                  mem_wdata_d = bus_if.dc_write_data;
                  mem_wmask_d = bus_if.dc_write_mask;
               end else begin
                  mem_rw_d    = norm_rw(bus_if.ic_rw_flag);
                  mem_addr_d  = bus_if.ic_addr;
                  mem_wdata_d = bus_if.ic_write_data;
                  mem_wmask_d = bus_if.ic_write_mask;
               end
`ifdef MEM_ARB_ROUND_ROBIN_EN
               ptr_d = ~w_gnt;
`endif
            end
         end
         REQ: begin
            // Write responses also capture read data; requesters ignore it.
            if (bus_if.mem_done) begin
               state_d  = RESP;
               mem_rw_d = RW_IDLE;
               if (gnt_q == GNT_DC) begin
                  dc_rdata_d = bus_if.mem_read_data;
                  dc_done_d  = 1'b1;
               end else begin
                  ic_rdata_d = bus_if.mem_read_data;
                  ic_done_d  = 1'b1;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            mem_rw_d = RW_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         gnt_q       <= GNT_IC;
         busy_q      <= 1'b0;
         mem_rw_q    <= RW_IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wmask_q <= '0;
         ic_rdata_q  <= '0;
         dc_rdata_q  <= '0;
         ic_done_q   <= 1'b0;
         dc_done_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         ptr_q       <= GNT_DC;
`endif
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         busy_q      <= busy_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         ic_rdata_q  <= ic_rdata_d;
         dc_rdata_q  <= dc_rdata_d;
         ic_done_q   <= ic_done_d;
         dc_done_q   <= dc_done_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign bus_if.mem_rw_flag    = mem_rw_q;
   assign bus_if.mem_addr       = mem_addr_q;
   assign bus_if.mem_write_data = mem_wdata_q;
   assign bus_if.mem_write_mask = mem_wmask_q;
   assign bus_if.ic_read_data   = ic_rdata_q;
   assign bus_if.dc_read_data   = dc_rdata_q;
   assign bus_if.ic_done        = ic_done_q;
   assign bus_if.dc_done        = dc_done_q;
   assign bus_if.ic_busy        = busy_q;
   assign bus_if.dc_busy        = busy_q;

endmodule : mem_arbiter
`default_nettype wire
